// File: rtl/gpc_4t_dfd_reader.sv
// -----------------------------------------------------------------------------
// gpc_4t_dfd_reader
// Debug engine that dumps one thread's register file out of a gpc_4t core
// over the CR space.  For each register k in [first_reg, last_reg] it posts a
// write of k to CR_THREADn_DFD_REG_ID, reads CR_THREADn_DFD_REG_DATA, and
// streams the (reg id, data) pair to a host-side consumer.
//
// Ports
//   QClk, RstQnnnH              clock, asynchronous active-high reset
//   start                       1-cycle dump request, honoured only in IDLE
//   core_id, thread_id          target core (8'hFF illegal) and thread
//   first_reg, last_reg         inclusive register range
//   busy, done, done_err        status; done pulses once, done_err = aborted
//   dump_valid/ready/reg_id/data  beat stream to the consumer
//   req_valid/ready/wr/addr/wdata CR request port (writes are posted)
//   rsp_valid, rsp_data         read response, 1-cycle valid
// -----------------------------------------------------------------------------
module gpc_4t_dfd_reader #(
   parameter int RSP_TIMEOUT = 64,
   parameter int NUM_REGS    = 32,
   localparam int RW = $clog2(NUM_REGS),
   localparam int TW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1
) (
   input  logic          QClk,
   input  logic          RstQnnnH,
   input  logic          start,
   input  logic [7:0]    core_id,
   input  logic [1:0]    thread_id,
   input  logic [RW-1:0] first_reg,
   input  logic [RW-1:0] last_reg,
   output logic          busy,
   output logic          done,
   output logic          done_err,
   output logic          dump_valid,
   input  logic          dump_ready,
   output logic [RW-1:0] dump_reg_id,
   output logic [31:0]   dump_data,
   output logic          req_valid,
   input  logic          req_ready,
   output logic          req_wr,
   output logic [31:0]   req_addr,
   output logic [31:0]   req_wdata,
   input  logic          rsp_valid,
   input  logic [31:0]   rsp_data
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_ID    = 3'd1,
      ST_RD_DATA  = 3'd2,
      ST_WAIT_RSP = 3'd3,
      ST_PUSH     = 3'd4,
      ST_FIN      = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [RW-1:0] cur_q, cur_d;
   logic [RW-1:0] last_q, last_d;
   logic [7:0]    core_q, core_d;
   logic [1:0]    thr_q, thr_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [31:0]   data_q, data_d;
   logic          err_q, err_d;

   logic [11:0]   id_off_s;
   logic [11:0]   data_off_s;

   // Per-thread CR offsets: the four threads' DFD registers are word-spaced.
   assign id_off_s   = 12'h160 + {8'h00, thr_q, 2'b00};
   assign data_off_s = 12'h170 + {8'h00, thr_q, 2'b00};

   // State and datapath registers.
   always_ff @(posedge QClk or posedge RstQnnnH) begin
      if (RstQnnnH) begin
         state_q <= ST_IDLE;
         cur_q   <= '0;
         last_q  <= '0;
         core_q  <= 8'h00;
         thr_q   <= 2'b00;
         timer_q <= '0;
         data_q  <= 32'h0000_0000;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         last_q  <= last_d;
         core_q  <= core_d;
         thr_q   <= thr_d;
         timer_q <= timer_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic for the dump sequencer.
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      last_d  = last_q;
      core_d  = core_q;
      thr_d   = thr_q;
      timer_d = timer_q;
      data_d  = data_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               core_d  = core_id;
               thr_d   = thread_id;
               cur_d   = first_reg;
               last_d  = last_reg;
               timer_d = '0;
               // Broadcast target or empty range: abort without bus traffic.
               if ((core_id == 8'hFF) || (first_reg > last_reg)) begin
                  err_d   = 1'b1;
                  state_d = ST_FIN;
               end else begin
                  err_d   = 1'b0;
                  state_d = ST_WR_ID;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WR_ID: begin
            if (req_ready) begin
               state_d = ST_RD_DATA;
            end else begin
               state_d = ST_WR_ID;
            end
         end
         ST_RD_DATA: begin
            if (req_ready) begin
               timer_d = '0;
               state_d = ST_WAIT_RSP;
            end else begin
               state_d = ST_RD_DATA;
            end
         end
         ST_WAIT_RSP: begin
            if (rsp_valid) begin
               data_d  = rsp_data;
               state_d = ST_PUSH;
            end else if (timer_q == TW'(RSP_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = ST_FIN;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_PUSH: begin
            if (dump_ready) begin
               // Terminate on last_reg before incrementing so id 31 never wraps.
               if (cur_q == last_q) begin
                  err_d   = 1'b0;
                  state_d = ST_FIN;
               end else begin
                  cur_d   = cur_q + RW'(1);
                  state_d = ST_WR_ID;
               end
            end else begin
               state_d = ST_PUSH;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode; address/data fields are zero whenever not presented.
   always_comb begin
      busy        = 1'b1;
      done        = 1'b0;
      done_err    = 1'b0;
      dump_valid  = 1'b0;
      dump_reg_id = '0;
      dump_data   = 32'h0000_0000;
      req_valid   = 1'b0;
      req_wr      = 1'b0;
      req_addr    = 32'h0000_0000;
      req_wdata   = 32'h0000_0000;
      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
         end
         ST_WR_ID: begin
            req_valid = 1'b1;
            req_wr    = 1'b1;
            req_addr  = {core_q, 2'b11, 10'b00_0000_0000, id_off_s};
            req_wdata = {{(32 - RW){1'b0}}, cur_q};
         end
         ST_RD_DATA: begin
            req_valid = 1'b1;
            req_addr  = {core_q, 2'b11, 10'b00_0000_0000, data_off_s};
         end
         ST_WAIT_RSP: begin
            busy = 1'b1;
         end
         ST_PUSH: begin
            dump_valid  = 1'b1;
            dump_reg_id = cur_q;
            dump_data   = data_q;
         end
         ST_FIN: begin
            done     = 1'b1;
            done_err = err_q;
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_gpc_4t_dfd_reader.sv
module tb_gpc_4t_dfd_reader;

   logic        QClk;
   logic        RstQnnnH;
   logic        start;
   logic [7:0]  core_id;
   logic [1:0]  thread_id;
   logic [4:0]  first_reg;
   logic [4:0]  last_reg;
   logic        busy;
   logic        done;
   logic        done_err;
   logic        dump_valid;
   logic        dump_ready;
   logic [4:0]  dump_reg_id;
   logic [31:0] dump_data;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_data;

   int n_cmp;
   int n_bad;

   gpc_4t_dfd_reader #(.RSP_TIMEOUT(64), .NUM_REGS(32)) dut (
      .QClk        (QClk),
      .RstQnnnH    (RstQnnnH),
      .start       (start),
      .core_id     (core_id),
      .thread_id   (thread_id),
      .first_reg   (first_reg),
      .last_reg    (last_reg),
      .busy        (busy),
      .done        (done),
      .done_err    (done_err),
      .dump_valid  (dump_valid),
      .dump_ready  (dump_ready),
      .dump_reg_id (dump_reg_id),
      .dump_data   (dump_data),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_wr      (req_wr),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data)
   );

   initial QClk = 1'b0;
   always #5 QClk = ~QClk;

   typedef struct {
      logic [7:0]  core;
      logic [1:0]  thr;
      logic [4:0]  first;
      logic [4:0]  last;
      bit          stall;
      bit          no_rsp;
      bit          repulse;
      logic [31:0] id_addr;
      logic [31:0] data_addr;
      logic [31:0] base;
      bit          illegal;
      bit          exp_err;
      int          exp_beats;
      int          exp_reqs;
      int          exp_wait;
   } vec_t;

   vec_t vecs[6];

   function automatic vec_t mk(logic [7:0] c, logic [1:0] t, logic [4:0] f, logic [4:0] l,
                               bit st, bit nr, bit rp, logic [31:0] ida, logic [31:0] da,
                               logic [31:0] b, bit il, bit er, int nb, int nq, int nw);
      vec_t v;
      v.core = c; v.thr = t; v.first = f; v.last = l;
      v.stall = st; v.no_rsp = nr; v.repulse = rp;
      v.id_addr = ida; v.data_addr = da; v.base = b;
      v.illegal = il; v.exp_err = er;
      v.exp_beats = nb; v.exp_reqs = nq; v.exp_wait = nw;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Runs one complete dump, acting as fabric and consumer, checking every cycle.
   task automatic run_dump(input vec_t v);
      int beats, wr_cnt, rd_cnt, wait_cnt, rsp_cnt, done_cyc, cyc;
      logic [4:0]  exp_cur;
      bit          seen_done, p_req_stall, p_dump_stall;
      logic [31:0] p_addr, p_wdata, p_data;
      logic        p_wr;
      logic [4:0]  p_reg;
      beats = 0; wr_cnt = 0; rd_cnt = 0; wait_cnt = 0; rsp_cnt = 0; done_cyc = -1;
      exp_cur = v.first; seen_done = 1'b0; p_req_stall = 1'b0; p_dump_stall = 1'b0;
      p_addr = 32'h0; p_wdata = 32'h0; p_data = 32'h0; p_wr = 1'b0; p_reg = 5'd0;
      core_id = v.core; thread_id = v.thr; first_reg = v.first; last_reg = v.last;
      req_ready = 1'b1; dump_ready = 1'b1; rsp_valid = 1'b0; rsp_data = 32'h0;
      start = 1'b1;
      @(negedge QClk);
      start = 1'b0;
      for (cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
         if (cyc == 0) begin
            chk("busy_after_start", 32'(busy), 32'(1));
            chk("req_valid_after_start", 32'(req_valid), 32'(!v.illegal));
         end
         if (p_req_stall) begin
            chk("req_valid_held", 32'(req_valid), 32'(1));
            chk("req_addr_held", req_addr, p_addr);
            chk("req_wr_held", 32'(req_wr), 32'(p_wr));
            chk("req_wdata_held", req_wdata, p_wdata);
         end
         if (p_dump_stall) begin
            chk("dump_valid_held", 32'(dump_valid), 32'(1));
            chk("dump_reg_held", 32'(dump_reg_id), 32'(p_reg));
            chk("dump_data_held", dump_data, p_data);
         end
         req_ready  = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
         dump_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
         rsp_valid = 1'b0;
         rsp_data  = 32'h0;
         if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0 && !v.no_rsp) begin
               rsp_valid = 1'b1;
               rsp_data  = v.base + 32'(exp_cur);
            end
         end
         if (busy && !req_valid && !dump_valid && !done) wait_cnt++;
         if (req_valid) begin
            if (req_wr) begin
               chk("wr_addr", req_addr, v.id_addr);
               chk("wr_wdata", req_wdata, 32'(exp_cur));
            end else begin
               chk("rd_addr", req_addr, v.data_addr);
               chk("rd_wdata", req_wdata, 32'h0);
            end
            if (req_ready) begin
               if (req_wr) wr_cnt++;
               else begin
                  rd_cnt++;
                  rsp_cnt = 2;
               end
            end
         end
         if (dump_valid) begin
            chk("beat_reg_id", 32'(dump_reg_id), 32'(exp_cur));
            chk("beat_data", dump_data, v.base + 32'(exp_cur));
            if (dump_ready) begin
               beats++;
               exp_cur = exp_cur + 5'd1;
            end
         end
         p_req_stall  = req_valid && !req_ready;
         p_dump_stall = dump_valid && !dump_ready;
         p_addr = req_addr; p_wdata = req_wdata; p_wr = req_wr;
         p_reg = dump_reg_id; p_data = dump_data;
         if (done) begin
            seen_done = 1'b1;
            done_cyc  = cyc;
            chk("done_err", 32'(done_err), 32'(v.exp_err));
         end
         start = (v.repulse && busy && !done) ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge QClk);
      end
      start = 1'b0;
      rsp_valid = 1'b0;
      chk("done_seen", 32'(seen_done), 32'(1));
      chk("beat_count", 32'(beats), 32'(v.exp_beats));
      chk("write_count", 32'(wr_cnt), 32'(v.exp_reqs));
      chk("read_count", 32'(rd_cnt), 32'(v.exp_reqs));
      chk("wait_cycles", 32'(wait_cnt), 32'(v.exp_wait));
      if (v.illegal) chk("illegal_done_latency", 32'(done_cyc), 32'(0));
      chk("done_single_pulse", 32'(done), 32'(0));
      chk("idle_after_done", 32'(busy), 32'(0));
      chk("no_req_after_done", 32'(req_valid), 32'(0));
   endtask

   initial begin
      bit found;
      vec_t v;
      n_cmp = 0;
      n_bad = 0;
      RstQnnnH = 1'b1;
      start = 1'b0; core_id = 8'h00; thread_id = 2'd0; first_reg = 5'd0; last_reg = 5'd0;
      dump_ready = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0;

      //            core   thr  first  last  stl nr rp  id_addr        data_addr      base          il er beats reqs wait
      vecs[0] = mk(8'h03, 2'd2, 5'd0,  5'd31, 0, 0, 0, 32'h03C0_0168, 32'h03C0_0178, 32'hA000_0000, 0, 0, 32,  32,  64);
      vecs[1] = mk(8'h00, 2'd0, 5'd5,  5'd5,  1, 0, 0, 32'h00C0_0160, 32'h00C0_0170, 32'h5555_0000, 0, 0, 1,   1,   2);
      vecs[2] = mk(8'hFF, 2'd1, 5'd0,  5'd3,  0, 0, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1, 1, 0,   0,   0);
      vecs[3] = mk(8'h01, 2'd0, 5'd9,  5'd4,  0, 0, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1, 1, 0,   0,   0);
      vecs[4] = mk(8'h12, 2'd3, 5'd7,  5'd9,  0, 1, 0, 32'h12C0_016C, 32'h12C0_017C, 32'h0000_0000, 0, 1, 0,   1,   64);
      vecs[5] = mk(8'hFE, 2'd1, 5'd30, 5'd31, 1, 0, 1, 32'hFEC0_0164, 32'hFEC0_0174, 32'h1234_5600, 0, 0, 2,   2,   4);

      // Reset state
      @(negedge QClk);
      @(negedge QClk);
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_req_valid", 32'(req_valid), 32'(0));
      chk("rst_dump_valid", 32'(dump_valid), 32'(0));
      chk("rst_req_addr", req_addr, 32'h0);
      RstQnnnH = 1'b0;
      @(negedge QClk);

      // Table-driven dumps
      for (int i = 0; i < 6; i++) begin
         run_dump(vecs[i]);
         @(negedge QClk);
      end

      // Reset during WAIT_RSP, then a late response after release
      core_id = 8'h04; thread_id = 2'd1; first_reg = 5'd0; last_reg = 5'd3;
      req_ready = 1'b1; dump_ready = 1'b1; rsp_valid = 1'b0;
      start = 1'b1;
      @(negedge QClk);
      start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (req_valid && !req_wr) found = 1'b1;
         @(negedge QClk);
      end
      chk("rst_seq_read_issued", 32'(found), 32'(1));
      chk("rst_seq_in_wait", 32'({busy, req_valid, dump_valid}), 32'(3'b100));
      RstQnnnH = 1'b1;
      #1;
      chk("async_rst_busy", 32'(busy), 32'(0));
      chk("async_rst_req", 32'({req_valid, req_wr}), 32'(0));
      chk("async_rst_addr", req_addr, 32'h0);
      chk("async_rst_dump", 32'({dump_valid, dump_reg_id}), 32'(0));
      chk("async_rst_done", 32'({done, done_err}), 32'(0));
      @(negedge QClk);
      RstQnnnH = 1'b0;
      @(negedge QClk);
      rsp_valid = 1'b1;
      rsp_data  = 32'hDEAD_BEEF;
      @(negedge QClk);
      rsp_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("late_rsp_ignored", 32'({busy, dump_valid, done, req_valid}), 32'(0));
         @(negedge QClk);
      end
      v = mk(8'h04, 2'd1, 5'd0, 5'd3, 0, 0, 0, 32'h04C0_0164, 32'h04C0_0174,
             32'hC0DE_0000, 0, 0, 4, 4, 8);
      run_dump(v);
      @(negedge QClk);

      // Spurious responses while idle
      for (int i = 0; i < 3; i++) begin
         rsp_valid = 1'b1;
         rsp_data  = 32'h0BAD_0000 + 32'(i);
         @(negedge QClk);
         chk("idle_rsp_ignored", 32'({busy, dump_valid, req_valid}), 32'(0));
      end
      rsp_valid = 1'b0;
      @(negedge QClk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
